// File: rtl/ece453_led_sequencer_pkg.sv
// Shared register map, control bit positions and state encoding for the LED sequencer.
package ece453_led_seq_pkg;
    localparam logic [4:0] ADDR_CONTROL = 5'd0;
    localparam logic [4:0] ADDR_STATUS  = 5'd1;
    localparam logic [4:0] ADDR_IM      = 5'd2;
    localparam logic [4:0] ADDR_IRQ     = 5'd3;
    localparam logic [4:0] ADDR_LEN     = 5'd4;
    localparam logic [4:0] ADDR_STEP0   = 5'd8;

    localparam int CTL_START  = 0;
    localparam int CTL_STOP   = 1;
    localparam int CTL_PAUSE  = 2;
    localparam int CTL_LOOP   = 3;
    localparam int CTL_MANUAL = 4;
    // START/STOP are pulses; only the mode bits are kept in the register
    localparam logic [4:0] CTL_MODE_MASK = 5'b11100;

    localparam int STEP_PAT_MSB = 31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } seq_state_t;
endpackage

// File: rtl/ece453_led_sequencer_if.sv
// Avalon-MM slave bus for the LED sequencer register file.
interface ece453_led_sequencer_if;
    logic [4:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;

    modport master (output slave_address, slave_read, slave_write, slave_writedata,
                    input  slave_readdata);
    modport slave  (input  slave_address, slave_read, slave_write, slave_writedata,
                    output slave_readdata);
endinterface

// File: rtl/ece453_led_sequencer_timer.sv
// Loadable dwell down-counter; expired flags the final cycle of a step.
module ece453_led_seq_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         enable,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  cnt <= '0;
        else if (load)                 cnt <= value;
        else if (enable && cnt != '0)  cnt <= cnt - 1'b1;
    end

    assign expired = enable && (cnt == '0);
endmodule

// File: rtl/ece453_led_sequencer.sv
// Pattern table sequencer driving the LED outputs, stepped by dwell timer or button.
module ece453_led_sequencer
    import ece453_led_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int PAT_W     = 8,
    parameter int DWELL_W   = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ece453_led_sequencer_if.slave  bus,
    input  logic                   advance,
    output logic [PAT_W-1:0]       led_out,
    output logic                   busy,
    output logic                   irq_out
);
    localparam int         IDX_W     = $clog2(NUM_STEPS);
    localparam logic [4:0] NSTEPS5   = 5'(NUM_STEPS);
    localparam logic [4:0] STEP_LAST = 5'(ADDR_STEP0 + 5'(NUM_STEPS - 1));

    seq_state_t         state, state_d;
    logic [IDX_W-1:0]   idx, load_idx;
    logic [4:0]         ctrl_r, len_reg, len_r, len_clamped;
    logic               im_r, irq_r;
    logic [PAT_W-1:0]   pat_tbl   [NUM_STEPS];
    logic [DWELL_W-1:0] dwell_tbl [NUM_STEPS];

    logic wr_ctl, wr_im, wr_irq, wr_len, step_sel, start, stop;
    logic load, clr_led, done, step_end, last, expired, tmr_en;
    logic [IDX_W-1:0] step_ix;

    assign wr_ctl   = bus.slave_write && bus.slave_address == ADDR_CONTROL;
    assign wr_im    = bus.slave_write && bus.slave_address == ADDR_IM;
    assign wr_irq   = bus.slave_write && bus.slave_address == ADDR_IRQ;
    assign wr_len   = bus.slave_write && bus.slave_address == ADDR_LEN;
    assign step_sel = bus.slave_address >= ADDR_STEP0 && bus.slave_address <= STEP_LAST;
    assign step_ix  = IDX_W'(bus.slave_address - ADDR_STEP0);
    assign start    = wr_ctl && bus.slave_writedata[CTL_START];
    assign stop     = wr_ctl && bus.slave_writedata[CTL_STOP];

    assign len_clamped = (len_reg == '0 || len_reg > NSTEPS5) ? NSTEPS5 : len_reg;
    assign last        = 5'(idx) == len_r - 5'd1;
    assign tmr_en      = state == ST_RUN && !ctrl_r[CTL_PAUSE] && !ctrl_r[CTL_MANUAL];

    ece453_led_seq_timer #(.W(DWELL_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .value   (dwell_tbl[load_idx]),
        .enable  (tmr_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_d;
    end

    // Bus commands are applied last so STOP beats START, and both beat a step end.
    always_comb begin
        state_d  = state;
        load     = 1'b0;
        load_idx = '0;
        clr_led  = 1'b0;
        done     = 1'b0;
        step_end = 1'b0;
        case (state)
            ST_RUN: begin
                if (ctrl_r[CTL_PAUSE]) state_d  = ST_PAUSED;
                else                   step_end = ctrl_r[CTL_MANUAL] ? advance : expired;
            end
            ST_PAUSED: if (!ctrl_r[CTL_PAUSE]) state_d = ST_RUN;
            default: ;
        endcase
        if (step_end) begin
            if (!last) begin
                load     = 1'b1;
                load_idx = idx + 1'b1;
            end else if (ctrl_r[CTL_LOOP]) begin
                load = 1'b1;
            end else begin
                state_d = ST_IDLE;
                done    = 1'b1;
            end
        end
        if (stop) begin
            state_d = ST_IDLE;
            clr_led = 1'b1;
            load    = 1'b0;
            done    = 1'b0;
        end else if (start) begin
            state_d  = ST_RUN;
            load     = 1'b1;
            load_idx = '0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx     <= '0;
            led_out <= '0;
            ctrl_r  <= '0;
            len_reg <= '0;
            len_r   <= '0;
            im_r    <= 1'b0;
            irq_r   <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                pat_tbl[i]   <= '0;
                dwell_tbl[i] <= '0;
            end
        end else begin
            if (load) begin
                idx     <= load_idx;
                led_out <= pat_tbl[load_idx];
            end else if (clr_led) begin
                led_out <= '0;
            end
            if (start && !stop) len_r   <= len_clamped;
            if (wr_ctl)         ctrl_r  <= bus.slave_writedata[4:0] & CTL_MODE_MASK;
            if (wr_im)          im_r    <= bus.slave_writedata[0];
            if (wr_len)         len_reg <= bus.slave_writedata[4:0];
            if (done)           irq_r   <= 1'b1;
            else if (wr_irq && bus.slave_writedata[0]) irq_r <= 1'b0;
            if (bus.slave_write && step_sel) begin
                pat_tbl[step_ix]   <= bus.slave_writedata[STEP_PAT_MSB -: PAT_W];
                dwell_tbl[step_ix] <= bus.slave_writedata[DWELL_W-1:0];
            end
        end
    end

    always_comb begin
        bus.slave_readdata = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                ADDR_CONTROL: bus.slave_readdata = {27'b0, ctrl_r};
                ADDR_STATUS:  bus.slave_readdata = {26'b0, state, 4'(idx)};
                ADDR_IM:      bus.slave_readdata = {31'b0, im_r};
                ADDR_IRQ:     bus.slave_readdata = {31'b0, irq_r};
                ADDR_LEN:     bus.slave_readdata = {27'b0, len_reg};
                default: if (step_sel) begin
                    bus.slave_readdata[STEP_PAT_MSB -: PAT_W] = pat_tbl[step_ix];
                    bus.slave_readdata[DWELL_W-1:0]          = dwell_tbl[step_ix];
                end
            endcase
        end
    end

    assign busy    = state != ST_IDLE;
    assign irq_out = im_r & irq_r;
endmodule

// File: tb/tb_ece453_led_sequencer.sv
// Directed-vector bench for the LED sequencer: timed, loop, manual, pause and corner cases.
module tb_ece453_led_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       advance;
    logic [7:0] led_out;
    logic       busy, irq_out;
    int         vecs = 0;
    int         errs = 0;

    ece453_led_sequencer_if bus();

    ece453_led_sequencer #(.NUM_STEPS(8), .PAT_W(8), .DWELL_W(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .advance (advance),
        .led_out (led_out),
        .busy    (busy),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        @(posedge clk);
        #1;
        bus.slave_write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        #1;
        d = bus.slave_readdata;
        bus.slave_read = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        bus.slave_address = '0; bus.slave_read = 0; bus.slave_write = 0;
        bus.slave_writedata = '0; advance = 0; reset_n = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        vecs++; if (led_out !== 8'h00) begin errs++; $display("FAIL reset_led got %h want 00", led_out); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
        vecs++; if (irq_out !== 1'b0) begin errs++; $display("FAIL reset_irq got %b want 0", irq_out); end
        rd(5'd0, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL reset_rd_ctl got %h want 0", d); end
        rd(5'd5, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL rd_unmapped got %h want 0", d); end
        rd(5'd8, d);
        vecs++; if (d !== 32'h0) begin errs++; $display("FAIL reset_step0 got %h want 0", d); end
    endtask

    task automatic test_timed;
        logic [31:0] d;
        logic [7:0]  exp;
        wr(5'd4, 32'd3);
        wr(5'd8,  32'h0100_0002);
        wr(5'd9,  32'h0200_0002);
        wr(5'd10, 32'h0400_0002);
        wr(5'd2, 32'd1);
        rd(5'd9, d);
        vecs++; if (d !== 32'h0200_0002) begin errs++; $display("FAIL rd_step1 got %h want 02000002", d); end
        bus.slave_address = 5'd9; #1;
        vecs++; if (bus.slave_readdata !== 32'h0) begin errs++; $display("FAIL rd_no_strobe got %h want 0", bus.slave_readdata); end
        wr(5'd0, 32'h01);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            exp = (k < 3) ? 8'h01 : (k < 6) ? 8'h02 : 8'h04;
            vecs++; if (led_out !== exp) begin errs++; $display("FAIL timed_led[%0d] got %h want %h", k, led_out, exp); end
        end
        @(negedge clk);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL timed_done_busy got %b want 0", busy); end
        vecs++; if (irq_out !== 1'b1) begin errs++; $display("FAIL timed_irq got %b want 1", irq_out); end
        vecs++; if (led_out !== 8'h04) begin errs++; $display("FAIL timed_hold got %h want 04", led_out); end
        rd(5'd1, d);
        vecs++; if (d !== 32'h02) begin errs++; $display("FAIL timed_status got %h want 02", d); end
        wr(5'd3, 32'd1);
        vecs++; if (irq_out !== 1'b0) begin errs++; $display("FAIL irq_w1c got %b want 0", irq_out); end
    endtask

    task automatic test_loop;
        logic [7:0] pats [3];
        pats = '{8'h01, 8'h02, 8'h04};
        wr(5'd0, 32'h09);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            vecs++; if (led_out !== pats[(k/3)%3]) begin errs++; $display("FAIL loop_led[%0d] got %h want %h", k, led_out, pats[(k/3)%3]); end
            vecs++; if (irq_out !== 1'b0) begin errs++; $display("FAIL loop_irq[%0d] got %b want 0", k, irq_out); end
        end
        wr(5'd0, 32'h02);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL stop_busy got %b want 0", busy); end
        vecs++; if (led_out !== 8'h00) begin errs++; $display("FAIL stop_led got %h want 00", led_out); end
        vecs++; if (irq_out !== 1'b0) begin errs++; $display("FAIL stop_irq got %b want 0", irq_out); end
    endtask

    task automatic test_manual;
        logic [31:0] d;
        logic [7:0]  exp_led [3];
        logic        exp_busy [3];
        exp_led  = '{8'h02, 8'h04, 8'h04};
        exp_busy = '{1'b1, 1'b1, 1'b0};
        wr(5'd0, 32'h11);
        repeat (20) @(negedge clk);
        vecs++; if (led_out !== 8'h01) begin errs++; $display("FAIL manual_hold got %h want 01", led_out); end
        for (int p = 0; p < 3; p++) begin
            advance = 1'b1;
            @(posedge clk); #1;
            advance = 1'b0;
            @(negedge clk);
            vecs++; if (led_out !== exp_led[p]) begin errs++; $display("FAIL manual_led[%0d] got %h want %h", p, led_out, exp_led[p]); end
            vecs++; if (busy !== exp_busy[p]) begin errs++; $display("FAIL manual_busy[%0d] got %b want %b", p, busy, exp_busy[p]); end
        end
        rd(5'd3, d);
        vecs++; if (d !== 32'h1) begin errs++; $display("FAIL manual_done got %h want 1", d); end
        wr(5'd3, 32'd1);
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0;
        @(negedge clk);
        vecs++; if (led_out !== 8'h04 || busy !== 1'b0 || irq_out !== 1'b0) begin
            errs++; $display("FAIL idle_advance got led=%h busy=%b irq=%b want 04/0/0", led_out, busy, irq_out);
        end
    endtask

    task automatic test_pause;
        logic [31:0] d;
        logic [7:0]  exp;
        bit          seen;
        wr(5'd0, 32'h01);
        repeat (4) @(negedge clk);
        vecs++; if (led_out !== 8'h02) begin errs++; $display("FAIL pause_pre got %h want 02", led_out); end
        wr(5'd0, 32'h04);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rd(5'd1, d);
            vecs++; if (led_out !== 8'h02 || d[3:0] !== 4'd1) begin
                errs++; $display("FAIL paused[%0d] got led=%h idx=%0d want 02/1", k, led_out, d[3:0]);
            end
        end
        wr(5'd0, 32'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = (k < 3) ? 8'h02 : 8'h04;
            vecs++; if (led_out !== exp) begin errs++; $display("FAIL resume_led[%0d] got %h want %h", k, led_out, exp); end
        end
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (!busy) seen = 1;
        end
        vecs++; if (!seen || irq_out !== 1'b1) begin errs++; $display("FAIL pause_done got done=%b irq=%b want 1/1", seen, irq_out); end
        wr(5'd3, 32'd1);
    endtask

    task automatic test_start_stop;
        logic [31:0] d;
        wr(5'd0, 32'h03);
        rd(5'd1, d);
        vecs++; if (busy !== 1'b0 || led_out !== 8'h00 || d[5:4] !== 2'd0) begin
            errs++; $display("FAIL start_stop got busy=%b led=%h st=%0d want 0/00/0", busy, led_out, d[5:4]);
        end
    endtask

    task automatic test_len0;
        wr(5'd4, 32'd0);
        for (int i = 0; i < 8; i++) wr(5'(8 + i), 32'(16 + i) << 24);
        wr(5'd0, 32'h01);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vecs++; if (led_out !== 8'(16 + k)) begin errs++; $display("FAIL len0_led[%0d] got %h want %h", k, led_out, 8'(16 + k)); end
        end
        @(negedge clk);
        vecs++; if (busy !== 1'b0 || irq_out !== 1'b1 || led_out !== 8'h17) begin
            errs++; $display("FAIL len0_done got busy=%b irq=%b led=%h want 0/1/17", busy, irq_out, led_out);
        end
        wr(5'd3, 32'd1);
    endtask

    task automatic test_done_w1c;
        logic [31:0] d;
        wr(5'd0, 32'h01);
        repeat (7) @(posedge clk);
        #1;
        wr(5'd3, 32'd1);
        rd(5'd3, d);
        vecs++; if (d !== 32'h1 || irq_out !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL set_vs_w1c got irq_reg=%h irq=%b busy=%b want 1/1/0", d, irq_out, busy);
        end
        wr(5'd3, 32'd1);
        vecs++; if (irq_out !== 1'b0) begin errs++; $display("FAIL w1c_after got %b want 0", irq_out); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(5'd0, 32'h01);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        rd(5'd8, d);
        vecs++; if (led_out !== 8'h00 || busy !== 1'b0 || irq_out !== 1'b0 || d !== 32'h0) begin
            errs++; $display("FAIL reset_mid got led=%h busy=%b irq=%b step0=%h want 00/0/0/0", led_out, busy, irq_out, d);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_timed;
        test_loop;
        test_manual;
        test_pause;
        test_start_stop;
        test_len0;
        test_done_w1c;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
